// File: rtl/dsp_accum_iter_sched.sv
// dsp_accum_iter_sched
// Round-robin job sequencer sharing one multiply-subtract accumulator DSP
// (z <= (a<<19) - z[19:0]*b, registered output, clear input) between NREQ
// requesters. An accepted job clears the DSP, drives its operands for
// max(iter,1) cycles, then returns the final z together with the requester id.
// Build option: define DSP_ACCUM_SCHED_PERF_EN to add saturating perf counters
// (perf_jobs, perf_busy).
module dsp_accum_iter_sched #(
  parameter int NREQ   = 2,
  parameter int ITER_W = 4,
  parameter int A_W    = 20,
  parameter int B_W    = 18,
  parameter int Z_W    = 38,
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*A_W-1:0]    req_a,
  input  logic [NREQ*B_W-1:0]    req_b,
  input  logic [NREQ*ITER_W-1:0] req_iter,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [Z_W-1:0]         resp_z,
  output logic [A_W-1:0]         dsp_a,
  output logic [B_W-1:0]         dsp_b,
  output logic                   dsp_reset,
  input  logic [Z_W-1:0]         dsp_z,
`ifdef DSP_ACCUM_SCHED_PERF_EN
  output logic                   busy,
  output logic [15:0]            perf_jobs,
  output logic [31:0]            perf_busy
`else
  output logic                   busy
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_reg;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [ID_W-1:0]   id_reg;
  logic [A_W-1:0]    a_reg;
  logic [B_W-1:0]    b_reg;
  logic [ITER_W-1:0] iter_reg;
  logic [ITER_W-1:0] cnt_reg;
  logic              resp_valid_reg;
  logic [ID_W-1:0]   resp_id_reg;
  logic [Z_W-1:0]    resp_z_reg;

  // Per-requester views of the packed job buses.
  logic [A_W-1:0]    a_arr    [NREQ];
  logic [B_W-1:0]    b_arr    [NREQ];
  logic [ITER_W-1:0] iter_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi]    = req_a[gi*A_W +: A_W];
      assign b_arr[gi]    = req_b[gi*B_W +: B_W];
      assign iter_arr[gi] = req_iter[gi*ITER_W +: ITER_W];
    end
  endgenerate

  logic            grant_found;
  logic [ID_W-1:0] grant_id;
  logic [ID_W:0]   cand;
  logic [ID_W-1:0] rr_ptr_next;
  logic [ITER_W-1:0] iter_eff;

  // Round-robin search: first valid requester at or after the RR pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NREQ)) cand = cand - (ID_W+1)'(NREQ);
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = cand[ID_W-1:0];
      end
    end
  end

  assign rr_ptr_next = (grant_id == ID_W'(NREQ-1)) ? '0 : grant_id + ID_W'(1);
  // A zero iteration count runs the DSP once, same as a count of one.
  assign iter_eff = (iter_arr[grant_id] == '0) ? ITER_W'(1) : iter_arr[grant_id];

  // Accept pulse only while idle and out of reset; at most one bit set.
  always_comb begin
    req_ready = '0;
    if (state_reg == S_IDLE && !reset && grant_found) req_ready[grant_id] = 1'b1;
  end

  // Job sequencing: accept, clear DSP, run iter cycles, present and hold result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      rr_ptr_reg     <= '0;
      id_reg         <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      iter_reg       <= '0;
      cnt_reg        <= '0;
      resp_valid_reg <= 1'b0;
      resp_id_reg    <= '0;
      resp_z_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (grant_found) begin
            a_reg      <= a_arr[grant_id];
            b_reg      <= b_arr[grant_id];
            iter_reg   <= iter_eff;
            id_reg     <= grant_id;
            rr_ptr_reg <= rr_ptr_next;
            state_reg  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          cnt_reg   <= iter_reg;
          state_reg <= S_RUN;
        end
        S_RUN: begin
          cnt_reg <= cnt_reg - ITER_W'(1);
          if (cnt_reg == ITER_W'(1)) state_reg <= S_DONE;
        end
        default: begin
          // dsp_z is only valid on the first DONE cycle (operands drop to zero),
          // so capture it once and then hold until the handshake.
          if (!resp_valid_reg) begin
            resp_valid_reg <= 1'b1;
            resp_z_reg     <= dsp_z;
            resp_id_reg    <= id_reg;
          end else if (resp_ready) begin
            resp_valid_reg <= 1'b0;
            state_reg      <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_reg;
  assign resp_id    = resp_id_reg;
  assign resp_z     = resp_z_reg;
  assign dsp_a      = (state_reg == S_RUN) ? a_reg : '0;
  assign dsp_b      = (state_reg == S_RUN) ? b_reg : '0;
  assign dsp_reset  = reset | (state_reg == S_CLEAR);
  assign busy       = (state_reg != S_IDLE);

`ifdef DSP_ACCUM_SCHED_PERF_EN
  logic [15:0] perf_jobs_reg;
  logic [31:0] perf_busy_reg;

  // Saturating counters of completed jobs and busy cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_jobs_reg <= '0;
      perf_busy_reg <= '0;
    end else begin
      if (resp_valid_reg && resp_ready && perf_jobs_reg != '1)
        perf_jobs_reg <= perf_jobs_reg + 16'd1;
      if (state_reg != S_IDLE && perf_busy_reg != '1)
        perf_busy_reg <= perf_busy_reg + 32'd1;
    end
  end

  assign perf_jobs = perf_jobs_reg;
  assign perf_busy = perf_busy_reg;
`endif

endmodule

// File: tb/tb_dsp_accum_iter_sched.sv
// Testbench for dsp_accum_iter_sched: behavioural DSP model, scoreboard of
// expected responses fed by a grant monitor, and a response monitor.
module tb_dsp_accum_iter_sched;
  localparam int NREQ = 2, ITER_W = 4, A_W = 20, B_W = 18, Z_W = 38, ID_W = 1;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*A_W-1:0]    req_a = '0;
  logic [NREQ*B_W-1:0]    req_b = '0;
  logic [NREQ*ITER_W-1:0] req_iter = '0;
  logic                   resp_valid;
  logic                   resp_ready = 1'b0;
  logic [ID_W-1:0]        resp_id;
  logic [Z_W-1:0]         resp_z;
  logic [A_W-1:0]         dsp_a;
  logic [B_W-1:0]         dsp_b;
  logic                   dsp_reset;
  logic [Z_W-1:0]         dsp_z = '0;
  logic                   busy;
`ifdef DSP_ACCUM_SCHED_PERF_EN
  logic [15:0]            perf_jobs;
  logic [31:0]            perf_busy;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int exp_id_q[$];
  logic [Z_W-1:0] exp_z_q[$];
  bit taken [NREQ];

  dsp_accum_iter_sched #(.NREQ(NREQ), .ITER_W(ITER_W), .A_W(A_W), .B_W(B_W), .Z_W(Z_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_iter(req_iter),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_z(resp_z),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_reset(dsp_reset), .dsp_z(dsp_z),
`ifdef DSP_ACCUM_SCHED_PERF_EN
    .busy(busy), .perf_jobs(perf_jobs), .perf_busy(perf_busy)
`else
    .busy(busy)
`endif
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural DSP primitive: clear, else z <= (a<<19) - z[19:0]*b mod 2^38.
  always @(posedge clk) begin
    if (dsp_reset) dsp_z <= '0;
    else dsp_z <= ({18'd0, dsp_a} << 19) - ({18'd0, dsp_z[19:0]} * {20'd0, dsp_b});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference result of one job: max(iter,1) multiply-subtract steps from zero.
  function automatic logic [Z_W-1:0] ref_z(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                          input logic [ITER_W-1:0] it);
    logic [Z_W-1:0] z;
    int n;
    z = '0;
    n = (it == 0) ? 1 : int'(it);
    for (int k = 0; k < n; k++)
      z = ({18'd0, a} << 19) - ({18'd0, z[19:0]} * {20'd0, b});
    return z;
  endfunction

  task automatic set_job(input int r, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                         input logic [ITER_W-1:0] it);
    req_a[r*A_W +: A_W]          = a;
    req_b[r*B_W +: B_W]          = b;
    req_iter[r*ITER_W +: ITER_W] = it;
  endtask

  task automatic set_rand_job(input int r);
    set_job(r, A_W'($urandom), B_W'($urandom), ITER_W'($urandom_range(0, 15)));
  endtask

  task automatic wait_ready(input int r, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = req_ready[r];
    end
    if (!ok) chk("grant_timeout", 64'(req_ready), 64'(1) << r);
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = resp_valid;
    end
    if (!ok) chk("resp_timeout", 64'(resp_valid), 64'(1));
  endtask

  task automatic drain();
    bit ok;
    @(posedge clk); #1;
    req_valid  = '0;
    resp_ready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      ok = !busy && !resp_valid;
    end
    if (!ok) chk("drain_timeout", 64'(busy), 64'(0));
  endtask

  // Directed single job with latency and literal result check.
  task automatic do_job(input int r, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                        input logic [ITER_W-1:0] it, input logic [Z_W-1:0] exp_z, input int exp_lat);
    bit ok;
    int acc_cyc;
    @(posedge clk); #1;
    set_job(r, a, b, it);
    req_valid[r] = 1'b1;
    wait_ready(r, ok);
    acc_cyc = cyc + 1;
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    wait_resp(ok);
    if (ok) begin
      chk("job_latency", 64'(cyc - acc_cyc), 64'(exp_lat));
      chk("job_resp_z", 64'(resp_z), 64'(exp_z));
      chk("job_resp_id", 64'(resp_id), 64'(r));
    end
  endtask

  // Grant monitor: checks arbitration against a round-robin model and pushes
  // the expected response for each accepted job.
  initial begin : grant_mon
    int rr_model;
    int w;
    int c;
    rr_model = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_id_q.delete();
        exp_z_q.delete();
        rr_model = 0;
        chk("reset_no_grant", 64'(req_ready), 64'(0));
      end else if (req_ready != '0) begin
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
          c = (rr_model + k) % NREQ;
          if (w < 0 && req_valid[c]) w = c;
        end
        chk("grant_while_busy", 64'(busy), 64'(0));
        chk("grant_winner", 64'(req_ready), (w < 0) ? 64'(0) : (64'(1) << w));
        if (w >= 0) begin
          exp_id_q.push_back(w);
          exp_z_q.push_back(ref_z(req_a[w*A_W +: A_W], req_b[w*B_W +: B_W],
                                  req_iter[w*ITER_W +: ITER_W]));
          rr_model = (w + 1) % NREQ;
          taken[w] = 1'b1;
        end
      end else if (!busy && req_valid != '0) begin
        chk("grant_missing", 64'(req_ready != '0), 64'(1));
      end
    end
  end

  // Response monitor: every cycle a response is presented it must match the
  // oldest outstanding job; it is retired on the handshake.
  initial begin : resp_mon
    forever begin
      @(negedge clk);
      if (!reset && resp_valid) begin
        if (exp_z_q.size() == 0) begin
          chk("resp_unexpected", 64'(resp_valid), 64'(0));
        end else begin
          chk("sb_resp_id", 64'(resp_id), 64'(exp_id_q[0]));
          chk("sb_resp_z", 64'(resp_z), 64'(exp_z_q[0]));
          if (resp_ready) begin
            void'(exp_id_q.pop_front());
            void'(exp_z_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit ok;
    logic [A_W-1:0] ha;
    logic [B_W-1:0] hb;
    logic [Z_W-1:0] hz;

    // Reset with both requesters valid.
    req_valid = 2'b11;
    set_job(0, 20'd1, 18'd1, 4'd1);
    set_job(1, 20'd2, 18'd2, 4'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_resp_valid", 64'(resp_valid), 64'(0));
      chk("rst_dsp_reset", 64'(dsp_reset), 64'(1));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_resp_z", 64'(resp_z), 64'(0));
    end
`ifdef DSP_ACCUM_SCHED_PERF_EN
    chk("rst_perf_jobs", 64'(perf_jobs), 64'(0));
`endif
    @(posedge clk); #1;
    reset      = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b1;

    // Directed jobs on requester 0.
    do_job(0, 20'd7, 18'd3, 4'd1, 38'd3670016, 3);
    do_job(0, 20'd7, 18'd3, 4'd2, 38'd2097152, 4);
    do_job(0, 20'd7, 18'd3, 4'd0, 38'd3670016, 3);

    // Result held while resp_ready is low; no accept until back in IDLE.
    @(posedge clk); #1;
    ha = 20'd12345;
    hb = 18'd777;
    hz = ref_z(ha, hb, 4'd3);
    resp_ready = 1'b0;
    set_job(0, ha, hb, 4'd3);
    req_valid[0] = 1'b1;
    wait_ready(0, ok);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    set_rand_job(1);
    req_valid[1] = 1'b1;
    wait_resp(ok);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("hold_resp_valid", 64'(resp_valid), 64'(1));
      chk("hold_resp_z", 64'(resp_z), 64'(hz));
      chk("hold_resp_id", 64'(resp_id), 64'(0));
      chk("hold_no_ready", 64'(req_ready), 64'(0));
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("accept_after_idle", 64'(req_ready), 64'(2'b10));
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    drain();

    // Both requesters valid every cycle: grants must alternate.
    @(posedge clk); #1;
    for (int r = 0; r < NREQ; r++) begin
      taken[r] = 1'b0;
      set_rand_job(r);
    end
    req_valid = 2'b11;
    for (int t = 0; t < 150; t++) begin
      @(posedge clk); #1;
      for (int r = 0; r < NREQ; r++)
        if (taken[r]) begin
          taken[r] = 1'b0;
          set_rand_job(r);
        end
    end
    drain();
    chk("alt_queue_empty", 64'(exp_z_q.size()), 64'(0));

    // Random traffic with random back-pressure.
    for (int r = 0; r < NREQ; r++) taken[r] = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(posedge clk); #1;
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < NREQ; r++) begin
        if (taken[r]) begin
          taken[r] = 1'b0;
          req_valid[r] = 1'b0;
        end
        if (!req_valid[r] && $urandom_range(0, 1) == 1) begin
          set_rand_job(r);
          req_valid[r] = 1'b1;
        end
      end
    end
    drain();
    chk("rand_queue_empty", 64'(exp_z_q.size()), 64'(0));

    // Reset in the middle of RUN discards the job.
    @(posedge clk); #1;
    set_job(1, 20'd99, 18'd5, 4'd8);
    req_valid = 2'b10;
    wait_ready(1, ok);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    set_job(0, 20'd3, 18'd1, 4'd1);
    set_job(1, 20'd4, 18'd1, 4'd1);
    req_valid = 2'b11;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("midrst_resp_valid", 64'(resp_valid), 64'(0));
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_dsp_reset", 64'(dsp_reset), 64'(1));
    end
`ifdef DSP_ACCUM_SCHED_PERF_EN
    chk("midrst_perf_jobs", 64'(perf_jobs), 64'(0));
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("first_after_reset", 64'(req_ready), 64'(2'b01));
    @(posedge clk); #1;
    req_valid = '0;
    drain();
`ifdef DSP_ACCUM_SCHED_PERF_EN
    chk("perf_jobs_one", 64'(perf_jobs), 64'(1));
`endif
    chk("final_queue_empty", 64'(exp_z_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dsp_accum_iter_sched.md
Name: dsp_accum_iter_sched

Overview:
- Sequencer and arbiter that shares one 20x18 multiply-subtract accumulator DSP between NREQ requesters.
- Datapath per clock edge: z <= (a<<19) - z[19:0]*b, modulo 2^38, with a registered output and a clear input.
- Each requester submits one job (a, b, iteration count). The block clears the DSP, drives operands for the requested number of cycles, then returns the final z with the requester id.
- Sits between host-side job queues and a single DSP accumulate primitive instance.

Parameters:
- NREQ, 2, number of requesters (2..4).
- ITER_W, 4, width of per-job iteration count.
- A_W, 20, operand a width; fixed by the DSP.
- B_W, 18, operand b width; fixed by the DSP.
- Z_W, 38, accumulator/result width; fixed by the DSP.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NREQ  per-requester job valid.
- req_ready  out  NREQ  one-hot accept pulse; at most one bit set.
- req_a  in  NREQ*A_W  packed operand a; requester i at [i*A_W +: A_W].
- req_b  in  NREQ*B_W  packed operand b.
- req_iter  in  NREQ*ITER_W  packed iteration count.
- resp_valid  out  1  result valid.
- resp_ready  in  1  result accepted.
- resp_id  out  clog2(NREQ) (min 1)  index of the requester that owns the result.
- resp_z  out  Z_W  final accumulator value.
- dsp_a  out  A_W  DSP operand a.
- dsp_b  out  B_W  DSP operand b.
- dsp_reset  out  1  DSP clear; accumulator is 0 after the edge.
- dsp_z  in  Z_W  DSP registered output.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (sync, any state): next state IDLE; RR pointer=0; req_ready=0; resp_valid=0; resp_id=0; resp_z=0; dsp_a=0; dsp_b=0; busy=0. dsp_reset = reset | (state==CLEAR), so the DSP is cleared while reset is high. A job in progress is discarded with no response.
- States: IDLE -> CLEAR -> RUN -> DONE -> IDLE.
- IDLE:
  - Arbitrate round-robin among req_valid, starting at the RR pointer.
  - Winner w gets req_ready[w]=1 combinationally in the same cycle; job data is sampled at that edge.
  - Latch a, b, iter and id. iter=0 is treated as 1. Go to CLEAR.
  - RR pointer becomes (w+1) mod NREQ.
  - With no req_valid, remain in IDLE.
- CLEAR: exactly 1 cycle; dsp_reset=1; dsp_a/dsp_b=0. Load the down-counter with iter. Go to RUN.
- RUN:
  - dsp_reset=0; dsp_a/dsp_b driven from the latched job; the counter decrements each cycle.
  - The DSP updates once per RUN cycle.
  - When the counter is 1, go to DONE; total RUN cycles = max(iter,1).
- DONE:
  - On entry edge+0, dsp_z holds the final value; capture it into resp_z and assert resp_valid with resp_id.
  - Hold resp_z, resp_id and resp_valid stable until resp_valid & resp_ready; at that edge clear resp_valid and go to IDLE.
  - dsp_a/dsp_b=0 in DONE.
- Latency: accept edge to resp_valid = 1 (CLEAR) + iter (RUN) + 1 (capture) cycles; minimum 3 cycles.
- No new job is accepted before IDLE, so there is at least one idle cycle between jobs.
- Requests that are not granted must stay asserted. No req_ready is issued outside IDLE.
- Arithmetic wraps modulo 2^Z_W inside the DSP; the controller does no arithmetic on z.
- Simultaneous valids: the RR pointer decides. After reset, requester 0 wins a tie.

Optional Feature:
- Macro: DSP_ACCUM_SCHED_PERF_EN.
- Defined:
  - Adds output perf_jobs[15:0], incremented on each response handshake.
  - Adds output perf_busy[31:0], incremented on each cycle with busy=1.
  - Both counters saturate at all-ones and are cleared by reset.
- Undefined: ports and logic are absent; the port list is exactly as above.

Test Plan:
- Reset with both req_valid high -> req_ready=0, resp_valid=0, dsp_reset=1, busy=0 while reset is asserted.
- Req0 a=7, b=3, iter=1 -> resp_z=3670016 (7<<19), resp_id=0, resp_valid 3 cycles after accept.
- Req0 a=7, b=3, iter=2 -> resp_z=2097152 (3670016 - 524288*3); resp_valid 4 cycles after accept; iter=0 gives the same result as iter=1.
- Req0 and req1 valid every cycle, resp_ready=1 -> grants alternate 0,1,0,1; each resp_id matches its grant; no job is lost.
- resp_ready held low 5 cycles in DONE -> resp_z and resp_id stable, no req_ready issued; accept follows the first IDLE cycle after the handshake.
- Reset asserted mid-RUN (iter=8, cycle 3) -> no response; first request after release is accepted by requester 0; PERF build: perf_jobs=0 after reset and 1 after one completed job.
